regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Architectural register file with pending-write scoreboard, the receiving end of the write-back bus driven by the MemWB pipeline stage. It accepts `regs_data`/`regs_wr_id`/`regs_write` from write-back, serves two registered read ports to decode, and tracks registers with an in-flight producer so decode can stall on RAW hazards. It sits between the MemWB stage output and the DecodeFetch stage input.

## Interface
- `REGS`, 32, number of architectural registers; power of two, 2..64; register 0 hardwired to zero
- `WIDTH`, 32, data width in bits
- `clk` in 1, single clock, all state on rising edge
- `reset` in 1, asynchronous, active-high; clears all state immediately
- `regs_data_in` in WIDTH, write-back data
- `regs_wr_id_in` in 32, write-back destination id; only low log2(REGS) bits used; values >= REGS ignored
- `regs_write_in` in 1, write-back strobe
- `rs1_id_in` in 32, read port 1 address
- `rs2_id_in` in 32, read port 2 address
- `rs1_data_out` out WIDTH, registered read data port 1
- `rs2_data_out` out WIDTH, registered read data port 2
- `issue_valid_in` in 1, decode issues an instruction that writes `issue_rd_in`
- `issue_rd_in` in 32, destination of issued instruction
- `hazard_out` out 1, combinational: rs1 or rs2 (nonzero) currently pending
- `pending_count_out` out log2(REGS)+1, number of busy registers

## Operation
- Storage: REGS x WIDTH array; busy bit per register.
- Write: when `regs_write_in` and id in range and id != 0, array[id] <= `regs_data_in`; busy[id] cleared.
- Issue: when `issue_valid_in` and rd in range and rd != 0, busy[rd] set.
- Same-cycle issue and write-back to same id: data written, busy stays set (new producer wins).
- Write-back to non-busy register: legal; data written, busy unchanged (0).
- Issue to already-busy register: busy stays 1; count unchanged.
- Read: rs*_data_out <= array[rs*_id_in] every cycle; id 0 or out of range -> 0.
- hazard_out = (busy[rs1] & rs1!=0) | (busy[rs2] & rs2!=0), out-of-range ids never hazard.
- pending_count_out = popcount of busy, registered alongside busy.

## Timing
- Reset values: array all 0, busy all 0, rs1/rs2_data_out 0, pending_count_out 0, hazard_out 0.
- Reset asserted mid-operation: everything cleared asynchronously; write/issue in that cycle discarded.
- Write latency: array updated at edge N; a read addressed at edge N+1 returns new data at N+1 output.
- Read latency: 1 cycle, address at edge N -> data valid after edge N.
- Busy set at edge of issue; visible on hazard_out the following cycle.
- Same-cycle read and write to same id: see Configuration.

## Configuration
- `REGFILE_BYPASS_EN` defined: read of an id being written in the same cycle returns `regs_data_in`; hazard_out masks a register whose busy bit is being cleared this cycle (unless re-issued same cycle).
- Not defined: same-cycle read returns old array contents; hazard_out stays asserted until the cycle after write-back. Decode must stall one extra cycle.

## Structure
- `regfile_pkg`: REGS/WIDTH defaults, `reg_id_t` typedef (log2(REGS) bits), `id_valid` function (in range and nonzero).
- One sub-module: `busy_table` — busy bit vector, set/clear priority, popcount; async reset.
- Top holds data array, read registers, bypass muxes, hazard logic.

## Test plan
- Reset during pending state: issue rd=5, assert reset -> busy 0, pending_count_out 0, reads of r5 return 0.
- Write r3=0xDEADBEEF, read r3 next cycle -> rs1_data_out 0xDEADBEEF after one cycle; write r0=0x1234 -> read r0 returns 0.
- Issue rd=7, rs1_id=7 -> hazard_out 1, pending_count_out 1; write-back r7=0x55 -> hazard 0 (next cycle without bypass, same cycle with `REGFILE_BYPASS_EN`).
- Same-cycle write r9=0xA5A5A5A5 and read r9 -> with bypass 0xA5A5A5A5, without previous value 0.
- Same-cycle issue rd=4 and write-back r4=0x10 -> array r4=0x10, busy[4] still 1, hazard on rs2=4 remains 1.
- Out-of-range ids (REGS=32, id=40) for write, issue, read -> no state change, read returns 0, no hazard.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, register-id type and id validation for the register file / scoreboard.
// Optional same-cycle bypass is enabled with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    localparam int REGS_DEFAULT  = 32;
    localparam int WIDTH_DEFAULT = 32;

    typedef logic [$clog2(REGS_DEFAULT)-1:0] reg_id_t;

    // Register 0 is hardwired to zero and ids at or above REGS are ignored,
    // so neither may write, issue, read data or raise a hazard.
    function automatic logic id_valid(input logic [31:0] id, input int unsigned regs);
        return (id != 32'd0) && (id < regs);
    endfunction

endpackage

// File: rtl/regfile_busy_table.sv
// Busy-bit vector for in-flight producers: issue sets, write-back clears,
// a set in the same cycle as a clear wins. Also keeps a registered popcount.
module busy_table
    import regfile_pkg::*;
#(
    parameter  int REGS = REGS_DEFAULT,
    localparam int IW   = $clog2(REGS),
    localparam int CW   = $clog2(REGS) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en_i,
    input  logic [IW-1:0]   set_idx_i,
    input  logic            clr_en_i,
    input  logic [IW-1:0]   clr_idx_i,
    output logic [REGS-1:0] busy_o,
    output logic [CW-1:0]   count_o
);

    logic [REGS-1:0] busy_q, busy_d;
    logic [CW-1:0]   count_q, count_d;

    // NOTE: every combinational output gets a default before any condition, so no latch is inferred.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
        if (set_en_i) busy_d[set_idx_i] = 1'b1;

        count_d = '0;
        for (int i = 0; i < REGS; i++) begin
            count_d = count_d + CW'(busy_d[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o  = busy_q;
    assign count_o = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with two registered read ports and a pending-write
// scoreboard for RAW stalls. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int REGS  = REGS_DEFAULT,
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int IW    = $clog2(REGS),
    localparam int CW    = $clog2(REGS) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] regs_data_in,
    input  logic [31:0]      regs_wr_id_in,
    input  logic             regs_write_in,
    input  logic [31:0]      rs1_id_in,
    input  logic [31:0]      rs2_id_in,
    output logic [WIDTH-1:0] rs1_data_out,
    output logic [WIDTH-1:0] rs2_data_out,
    input  logic             issue_valid_in,
    input  logic [31:0]      issue_rd_in,
    output logic             hazard_out,
    output logic [CW-1:0]    pending_count_out
);

    logic            wr_ok, iss_ok, rs1_ok, rs2_ok;
    logic [IW-1:0]   wr_idx, iss_idx, rs1_idx, rs2_idx;
    logic [REGS-1:0] busy;
    logic [WIDTH-1:0] mem_q [REGS];
    logic [WIDTH-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
    logic            rs1_haz, rs2_haz;

    assign wr_ok   = regs_write_in  && id_valid(regs_wr_id_in, unsigned'(REGS));
    assign iss_ok  = issue_valid_in && id_valid(issue_rd_in, unsigned'(REGS));
    assign rs1_ok  = id_valid(rs1_id_in, unsigned'(REGS));
    assign rs2_ok  = id_valid(rs2_id_in, unsigned'(REGS));
    assign wr_idx  = regs_wr_id_in[IW-1:0];
    assign iss_idx = issue_rd_in[IW-1:0];
    assign rs1_idx = rs1_id_in[IW-1:0];
    assign rs2_idx = rs2_id_in[IW-1:0];

    busy_table #(.REGS(REGS)) u_busy (
        .clk       (clk),
        .reset     (reset),
        .set_en_i  (iss_ok),
        .set_idx_i (iss_idx),
        .clr_en_i  (wr_ok),
        .clr_idx_i (wr_idx),
        .busy_o    (busy),
        .count_o   (pending_count_out)
    );

    // NOTE: the array is cleared on reset because reset must leave every register reading zero;
    // this costs a reset net on every bit and rules out mapping to a plain RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REGS; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_idx] <= regs_data_in;
        end
    end

    always_comb begin
        rs1_data_d = '0;
        rs2_data_d = '0;
        if (rs1_ok) rs1_data_d = mem_q[rs1_idx];
        if (rs2_ok) rs2_data_d = mem_q[rs2_idx];
`ifdef REGFILE_BYPASS_EN
        if (rs1_ok && wr_ok && (wr_idx == rs1_idx)) rs1_data_d = regs_data_in;
        if (rs2_ok && wr_ok && (wr_idx == rs2_idx)) rs2_data_d = regs_data_in;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1_data_q <= '0;
            rs2_data_q <= '0;
        end else begin
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
        end
    end

    assign rs1_data_out = rs1_data_q;
    assign rs2_data_out = rs2_data_q;

`ifdef REGFILE_BYPASS_EN
    // A write-back retiring the producer hides the hazard now, unless a new producer issues to it.
    logic wb_retire;
    assign wb_retire = wr_ok && !(iss_ok && (iss_idx == wr_idx));
    assign rs1_haz   = rs1_ok && busy[rs1_idx] && !(wb_retire && (wr_idx == rs1_idx));
    assign rs2_haz   = rs2_ok && busy[rs2_idx] && !(wb_retire && (wr_idx == rs2_idx));
`else
    assign rs1_haz   = rs1_ok && busy[rs1_idx];
    assign rs2_haz   = rs2_ok && busy[rs2_idx];
`endif

    assign hazard_out = rs1_haz || rs2_haz;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table, mid-operation
// reset sequence, then random traffic against a behavioural model.
module tb_regfile_scoreboard;

    localparam int REGS  = 32;
    localparam int WIDTH = 32;
    localparam int CW    = $clog2(REGS) + 1;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] regs_data_in;
    logic [31:0]      regs_wr_id_in;
    logic             regs_write_in;
    logic [31:0]      rs1_id_in, rs2_id_in;
    logic [WIDTH-1:0] rs1_data_out, rs2_data_out;
    logic             issue_valid_in;
    logic [31:0]      issue_rd_in;
    logic             hazard_out;
    logic [CW-1:0]    pending_count_out;

    int errors = 0;
    int checks = 0;

    regfile_scoreboard #(.REGS(REGS), .WIDTH(WIDTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .regs_data_in      (regs_data_in),
        .regs_wr_id_in     (regs_wr_id_in),
        .regs_write_in     (regs_write_in),
        .rs1_id_in         (rs1_id_in),
        .rs2_id_in         (rs2_id_in),
        .rs1_data_out      (rs1_data_out),
        .rs2_data_out      (rs2_data_out),
        .issue_valid_in    (issue_valid_in),
        .issue_rd_in       (issue_rd_in),
        .hazard_out        (hazard_out),
        .pending_count_out (pending_count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural reference: plain arrays updated from the architectural rules.
    logic [WIDTH-1:0] m_mem  [REGS];
    bit               m_busy [REGS];
    logic [WIDTH-1:0] exp_r1, exp_r2;

    function automatic bit m_valid(input logic [31:0] id);
        return (id != 0) && (id < REGS);
    endfunction

    function automatic logic [WIDTH-1:0] m_read(input logic [31:0] id);
        if (!m_valid(id)) return '0;
        if (BYP && regs_write_in && regs_wr_id_in == id) return regs_data_in;
        return m_mem[id];
    endfunction

    function automatic bit m_pending(input logic [31:0] id);
        if (!m_valid(id) || !m_busy[id]) return 1'b0;
        if (BYP && regs_write_in && regs_wr_id_in == id && !(issue_valid_in && issue_rd_in == id))
            return 1'b0;
        return 1'b1;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < REGS; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < REGS; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        exp_r1 = m_read(rs1_id_in);
        exp_r2 = m_read(rs2_id_in);
        if (regs_write_in && m_valid(regs_wr_id_in)) begin
            m_mem[regs_wr_id_in]  = regs_data_in;
            m_busy[regs_wr_id_in] = 1'b0;
        end
        if (issue_valid_in && m_valid(issue_rd_in)) m_busy[issue_rd_in] = 1'b1;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] wid;
        logic [31:0] wdata;
        logic        iss;
        logic [31:0] ird;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        haz;
        logic [31:0] e1;
        logic [31:0] e2;
        int          cnt;
    } vec_t;

    // Called just after a rising edge: drive, check hazard mid-cycle, clock, check registered outputs.
    task automatic apply(input vec_t v, input bit use_tbl);
        regs_write_in  = v.wr;
        regs_wr_id_in  = v.wid;
        regs_data_in   = v.wdata;
        issue_valid_in = v.iss;
        issue_rd_in    = v.ird;
        rs1_id_in      = v.rs1;
        rs2_id_in      = v.rs2;
        @(negedge clk);
        check("hazard_model", 32'(hazard_out), 32'(m_pending(rs1_id_in) || m_pending(rs2_id_in)));
        if (use_tbl) check("hazard_tbl", 32'(hazard_out), 32'(v.haz));
        @(posedge clk);
        model_step();
        #1;
        check("rs1_model", rs1_data_out, exp_r1);
        check("rs2_model", rs2_data_out, exp_r2);
        check("count_model", 32'(pending_count_out), 32'(m_count()));
        if (use_tbl) begin
            check("rs1_tbl", rs1_data_out, v.e1);
            check("rs2_tbl", rs2_data_out, v.e2);
            check("count_tbl", 32'(pending_count_out), 32'(v.cnt));
        end
    endtask

    vec_t vecs [17];
    vec_t v;

    initial begin
        //           wr  wid  wdata          iss ird rs1 rs2 haz        e1                          e2                          cnt
        vecs[0]  = '{1, 3,  32'hDEADBEEF, 0, 0,  3,  0,  0,        BYP ? 32'hDEADBEEF : 32'h0, 32'h0,                      0};
        vecs[1]  = '{1, 0,  32'h00001234, 0, 0,  3,  0,  0,        32'hDEADBEEF,               32'h0,                      0};
        vecs[2]  = '{0, 0,  32'h0,        0, 0,  0,  3,  0,        32'h0,                      32'hDEADBEEF,               0};
        vecs[3]  = '{0, 0,  32'h0,        1, 7,  7,  0,  0,        32'h0,                      32'h0,                      1};
        vecs[4]  = '{0, 0,  32'h0,        0, 0,  7,  0,  1,        32'h0,                      32'h0,                      1};
        vecs[5]  = '{1, 7,  32'h00000055, 0, 0,  7,  0,  !BYP,     BYP ? 32'h55 : 32'h0,       32'h0,                      0};
        vecs[6]  = '{0, 0,  32'h0,        0, 0,  7,  0,  0,        32'h55,                     32'h0,                      0};
        vecs[7]  = '{1, 9,  32'hA5A5A5A5, 0, 0,  9,  9,  0,        BYP ? 32'hA5A5A5A5 : 32'h0, BYP ? 32'hA5A5A5A5 : 32'h0, 0};
        vecs[8]  = '{0, 0,  32'h0,        0, 0,  9,  0,  0,        32'hA5A5A5A5,               32'h0,                      0};
        vecs[9]  = '{1, 4,  32'h00000010, 1, 4,  0,  4,  0,        32'h0,                      BYP ? 32'h10 : 32'h0,       1};
        vecs[10] = '{0, 0,  32'h0,        0, 0,  0,  4,  1,        32'h0,                      32'h10,                     1};
        vecs[11] = '{1, 4,  32'h00000020, 1, 4,  0,  4,  1,        32'h0,                      BYP ? 32'h20 : 32'h10,      1};
        vecs[12] = '{1, 35, 32'hFFFFFFFF, 1, 40, 40, 4,  1,        32'h0,                      32'h20,                     1};
        vecs[13] = '{1, 4,  32'h00000030, 0, 0,  4,  40, !BYP,     BYP ? 32'h30 : 32'h20,      32'h0,                      0};
        vecs[14] = '{0, 0,  32'h0,        0, 0,  4,  7,  0,        32'h30,                     32'h55,                     0};
        vecs[15] = '{0, 0,  32'h0,        0, 0,  35, 3,  0,        32'h0,                      32'hDEADBEEF,               0};
        vecs[16] = '{0, 0,  32'h0,        1, 5,  3,  0,  0,        32'hDEADBEEF,               32'h0,                      1};

        reset = 1'b1;
        regs_write_in = 0; regs_wr_id_in = 0; regs_data_in = 0;
        issue_valid_in = 0; issue_rd_in = 0; rs1_id_in = 0; rs2_id_in = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_rs1", rs1_data_out, 32'h0);
        check("reset_rs2", rs2_data_out, 32'h0);
        check("reset_count", 32'(pending_count_out), 32'h0);
        check("reset_hazard", 32'(hazard_out), 32'h0);
        @(posedge clk);
        model_step();
        #1;

        for (int i = 0; i < 17; i++) apply(vecs[i], 1'b1);

        // Reset asserted mid-cycle while r5 is pending and a write/issue is on the bus.
        regs_write_in = 1; regs_wr_id_in = 5; regs_data_in = 32'h77;
        issue_valid_in = 1; issue_rd_in = 6; rs1_id_in = 5; rs2_id_in = 6;
        #2;
        reset = 1'b1;
        #1;
        check("midreset_rs1", rs1_data_out, 32'h0);
        check("midreset_count", 32'(pending_count_out), 32'h0);
        check("midreset_hazard", 32'(hazard_out), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        regs_write_in = 0; issue_valid_in = 0; rs1_id_in = 0; rs2_id_in = 0;
        @(posedge clk);
        model_step();
        #1;
        v = '{0, 0, 32'h0, 0, 0, 5, 6, 0, 32'h0, 32'h0, 0};
        apply(v, 1'b1);
        v = '{0, 0, 32'h0, 0, 0, 3, 5, 0, 32'h0, 32'h0, 0};
        apply(v, 1'b1);

        for (int n = 0; n < 400; n++) begin
            v.wr    = ($urandom % 2) == 0;
            v.wid   = $urandom_range(0, 39);
            v.wdata = $urandom;
            v.iss   = ($urandom % 3) == 0;
            v.ird   = ($urandom % 4 == 0) ? v.wid : 32'($urandom_range(0, 39));
            v.rs1   = ($urandom % 4 == 0) ? v.wid : 32'($urandom_range(0, 39));
            v.rs2   = ($urandom % 4 == 0) ? v.ird : 32'($urandom_range(0, 39));
            apply(v, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
